// File: rtl/datamemory_lanes.sv
// Word-organised data memory with byte/half/word lanes, load extension and a
// READ_LATENCY-deep read pipeline. Define DATAMEMORY_ALIGN_CHECK_EN to reject misaligned accesses.
module datamemory_lanes #(
  parameter int ADDRWIDTH    = 32,
  parameter int DEPTH        = 2**14,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req,
  output logic                 ready,
  input  logic                 we,
  input  logic [1:0]           size,
  input  logic                 unsigned_ld,
  input  logic [ADDRWIDTH-1:0] address,
  input  logic [31:0]          wdata,
  output logic                 rvalid,
  input  logic                 rready,
  output logic [31:0]          rdata,
  output logic                 err
);

  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic [1:0] lane;
    logic [1:0] size;
    logic       uns;
  } meta_t;

  logic [IW-1:0] idx;
  logic [1:0]    lane;
  logic          accept, illegal, stall, ld_acc, wr_acc;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic          unused_addr;

  logic [31:0]   mem    [DEPTH];
  logic [31:0]   raw_q  [READ_LATENCY];
  meta_t         meta_q [READ_LATENCY];
  logic          vld_q  [READ_LATENCY];

  assign idx         = address[IW+1:2];
  assign lane        = address[1:0];
  assign unused_addr = ^address[ADDRWIDTH-1:IW+2];

  assign stall  = rvalid && !rready;
  assign ready  = !stall;
  assign accept = req && ready;
  assign ld_acc = accept && !we && !illegal;
  assign wr_acc = accept &&  we && !illegal;

  always_comb begin
    illegal = (size == 2'b11);
`ifdef DATAMEMORY_ALIGN_CHECK_EN
    if (size == 2'b01 && lane[0])       illegal = 1'b1;
    if (size == 2'b10 && lane != 2'b00) illegal = 1'b1;
`endif
  end

  // Without the alignment check, misaligned halves/words are silently aligned here.
  always_comb begin
    case (size)
      2'b00:   begin be = 4'b0001 << lane;                   wlane = {4{wdata[7:0]}};  end
      2'b01:   begin be = lane[1] ? 4'b1100 : 4'b0011;        wlane = {2{wdata[15:0]}}; end
      default: begin be = 4'b1111;                            wlane = wdata;            end
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

  // Raw word and lane info travel the pipeline; extension is applied at the output.
  always_ff @(posedge clk) begin
    if (!stall) begin
      raw_q[0]  <= mem[idx];
      meta_q[0] <= meta_t'{lane: lane, size: size, uns: unsigned_ld};
      for (int i = 1; i < READ_LATENCY; i++) begin
        raw_q[i]  <= raw_q[i-1];
        meta_q[i] <= meta_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < READ_LATENCY; i++) vld_q[i] <= 1'b0;
      err <= 1'b0;
    end else begin
      err <= accept && illegal;
      if (!stall) begin
        vld_q[0] <= ld_acc;
        for (int i = 1; i < READ_LATENCY; i++) vld_q[i] <= vld_q[i-1];
      end
    end
  end

  assign rvalid = vld_q[READ_LATENCY-1];

  meta_t       m;
  logic [31:0] w, ext;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    m      = meta_q[READ_LATENCY-1];
    w      = raw_q[READ_LATENCY-1];
    byte_v = w[8*m.lane +: 8];
    half_v = m.lane[1] ? w[31:16] : w[15:0];
    case (m.size)
      2'b00:   ext = {{24{~m.uns & byte_v[7]}}, byte_v};
      2'b01:   ext = {{16{~m.uns & half_v[15]}}, half_v};
      default: ext = w;
    endcase
    rdata = rvalid ? ext : 32'h0;
  end

endmodule

// File: tb/tb_datamemory_lanes.sv
// Directed self-checking bench for datamemory_lanes: lanes, extension, backpressure,
// error pulses and reset behaviour; expectations follow DATAMEMORY_ALIGN_CHECK_EN.
module tb_datamemory_lanes;
  localparam int LAT = 1;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        req = 1'b0, we = 1'b0, unsigned_ld = 1'b0, rready = 1'b1;
  logic [1:0]  size = 2'b10;
  logic [31:0] address = '0, wdata = '0;
  logic        ready, rvalid, err;
  logic [31:0] rdata;
  int          total = 0, bad = 0;

  datamemory_lanes #(.ADDRWIDTH(32), .DEPTH(2**14), .READ_LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .ready(ready), .we(we), .size(size),
    .unsigned_ld(unsigned_ld), .address(address), .wdata(wdata), .rvalid(rvalid),
    .rready(rready), .rdata(rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = w; size = sz; unsigned_ld = u; address = a; wdata = d;
    tick();
    req = 1'b0; we = 1'b0;
  endtask

  task automatic load_chk(input string tag, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] exp);
    issue(1'b0, sz, u, a, 32'h0);
    repeat (LAT-1) tick();
    #1;
    check({tag, "_v"}, 32'(rvalid), 32'd1);
    check(tag, rdata, exp);
    tick();
    check({tag, "_end"}, 32'(rvalid), 32'd0);
  endtask

  task automatic reject_chk(input string tag, input logic w, input logic [1:0] sz,
                            input logic [31:0] a);
    issue(w, sz, 1'b0, a, 32'h0);
    repeat (LAT-1) begin
      check({tag, "_nov"}, 32'(rvalid), 32'd0);
      tick();
    end
    check({tag, "_err"}, 32'(err), 32'd1);
    check({tag, "_nov"}, 32'(rvalid), 32'd0);
    tick();
    check({tag, "_errclr"}, 32'(err), 32'd0);
    check({tag, "_nov2"}, 32'(rvalid), 32'd0);
  endtask

  logic [31:0] exp4 [4];
  int issued, got, held;
  logic take, acc;

  initial begin
    #12 reset_n = 1'b1;
    tick();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_err", 32'(err), 32'd0);

    // word store then load
    issue(1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678);
    check("sw_norv", 32'(rvalid), 32'd0);
    check("sw_noerr", 32'(err), 32'd0);
    load_chk("lw40", 2'b10, 1'b0, 32'h40, 32'h12345678);

    // byte lane store
    issue(1'b1, 2'b00, 1'b0, 32'h41, 32'h000000AB);
    load_chk("lb41", 2'b00, 1'b0, 32'h41, 32'hFFFFFFAB);
    load_chk("lbu41", 2'b00, 1'b1, 32'h41, 32'h000000AB);
    load_chk("lw40b", 2'b10, 1'b0, 32'h40, 32'h1234AB78);

    // half lane store
    issue(1'b1, 2'b01, 1'b0, 32'h42, 32'h00008001);
    load_chk("lh42", 2'b01, 1'b0, 32'h42, 32'hFFFF8001);
    load_chk("lhu42", 2'b01, 1'b1, 32'h42, 32'h00008001);
    load_chk("lb40", 2'b00, 1'b0, 32'h40, 32'h00000078);
    load_chk("lh40", 2'b01, 1'b0, 32'h40, 32'hFFFFAB78);
    load_chk("lw40c", 2'b10, 1'b0, 32'h40, 32'h8001AB78);

    // backpressure: four back-to-back loads, rready low for three cycles at first rvalid
    exp4[0] = 32'hA0000001; exp4[1] = 32'hB0000002;
    exp4[2] = 32'hC0000003; exp4[3] = 32'hD0000004;
    for (int i = 0; i < 4; i++) issue(1'b1, 2'b10, 1'b0, 32'h100 + 32'(i*4), exp4[i]);
    issued = 0; got = 0; held = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      req = (issued < 4); we = 1'b0; size = 2'b10; unsigned_ld = 1'b0;
      address = 32'h100 + 32'(issued*4);
      rready = !(rvalid && held < 3);
      #1;
      if (rvalid && !rready) begin
        held++;
        check("bp_ready", 32'(ready), 32'd0);
        check("bp_hold", rdata, exp4[got]);
      end
      take = rvalid && rready;
      acc  = req && ready;
      if (take) begin
        check("bp_data", rdata, exp4[got]);
        got++;
      end
      tick();
      if (acc) issued++;
    end
    req = 1'b0; rready = 1'b1;
    check("bp_got", 32'(got), 32'd4);
    check("bp_issued", 32'(issued), 32'd4);
    check("bp_held", 32'(held), 32'd3);
    tick();
    check("bp_nodup", 32'(rvalid), 32'd0);

    // misaligned and illegal-size requests
`ifdef DATAMEMORY_ALIGN_CHECK_EN
    reject_chk("lw41_rej", 1'b0, 2'b10, 32'h41);
    reject_chk("lh43_rej", 1'b0, 2'b01, 32'h43);
`else
    load_chk("lw41_al", 2'b10, 1'b0, 32'h41, 32'h8001AB78);
    load_chk("lh43_al", 2'b01, 1'b0, 32'h43, 32'hFFFF8001);
`endif
    reject_chk("ld_sz11", 1'b0, 2'b11, 32'h40);
    reject_chk("st_sz11", 1'b1, 2'b11, 32'h40);
    load_chk("lw40_kept", 2'b10, 1'b0, 32'h40, 32'h8001AB78);

    // reset with loads in flight
    req = 1'b1; we = 1'b0; size = 2'b10; address = 32'h40;
    tick();
    address = 32'h100;
    tick();
    req = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rstm_rvalid", 32'(rvalid), 32'd0);
    check("rstm_rdata", rdata, 32'h0);
    check("rstm_err", 32'(err), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstm_norv", 32'(rvalid), 32'd0);
    end
    load_chk("lw40_post", 2'b10, 1'b0, 32'h40, 32'h8001AB78);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
